// File: rtl/ring_pkg.sv
// Shared constants and state type for the serial ring memory and its consumers.
package ring_pkg;

  localparam int unsigned RING_WORD_COUNT    = 20;
  localparam int unsigned RING_PHASE_W       = 3;
  localparam int unsigned RING_BITS_PER_WORD = 8;
  localparam int unsigned RING_ADDR_W        = $clog2(RING_WORD_COUNT);

  // Sequencer command progress.
  typedef enum logic [1:0] {
    IDLE,
    WAIT_WR,
    SHIFT,
    WAIT_RD
  } seq_state_t;

endpackage

// File: rtl/ring_access_sequencer_if.sv
// Command/response handshake between a requester and the ring access sequencer.
interface ring_access_sequencer_if
  import ring_pkg::*;
#(
  parameter int unsigned ADDR_W = RING_ADDR_W,
  parameter int unsigned DATA_W = RING_BITS_PER_WORD
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  // Requester side.
  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ring_position_tracker.sv
// Mirrors the ring's bit phase and slot rotation so a consumer knows which
// byte is passing the write port and which byte is on the parallel output.
module ring_position_tracker
  import ring_pkg::*;
#(
  parameter int unsigned WORD_COUNT = RING_WORD_COUNT,
  parameter int unsigned SLOT_W     = $clog2(WORD_COUNT),
  parameter int unsigned PHASE_W    = RING_PHASE_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PHASE_W-1:0] phase,
  output logic [SLOT_W-1:0]  slot,
  output logic [SLOT_W-1:0]  next_slot
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORD_COUNT - 1);

  // Slot that follows the current one, wrapping at the end of the ring.
  assign next_slot = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);

  // Phase counts every clock; slot advances as the last bit of a byte passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      slot  <= '0;
    end else begin
      phase <= phase + PHASE_W'(1);
      if (phase == '1) begin
        slot <= next_slot;
      end
    end
  end

endmodule

// File: rtl/ring_access_sequencer.sv
// Front-end for the serial ring memory: turns byte read/write commands into the
// ring's serial write stream and captures read bytes at the right rotation slot.
module ring_access_sequencer
  import ring_pkg::*;
#(
  parameter int unsigned WORD_COUNT = RING_WORD_COUNT,
  parameter int unsigned ADDR_W     = $clog2(WORD_COUNT)
) (
  input  logic                          clk,
  input  logic                          reset,
  ring_access_sequencer_if.slave        bus,
  input  logic [RING_BITS_PER_WORD-1:0] ring_q,
  output logic                          ring_write,
  output logic                          ring_din,
  output logic [ADDR_W-1:0]             slot_addr
);

  localparam int unsigned DATA_W  = RING_BITS_PER_WORD;
  localparam int unsigned PHASE_W = RING_PHASE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  slot;
  logic [ADDR_W-1:0]  next_slot;

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               cmd_load;
  logic               rsp_valid_q;
  logic               rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic [DATA_W-1:0]  rsp_rdata_d;

  logic               addr_ok_c;
  logic               phase_last_c;
  logic [ADDR_W-1:0]  rd_slot_c;
  logic               rd_hit_c;

  ring_position_tracker #(
    .WORD_COUNT (WORD_COUNT),
    .SLOT_W     (ADDR_W),
    .PHASE_W    (PHASE_W)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .phase     (phase),
    .slot      (slot),
    .next_slot (next_slot)
  );

  // Address decode and capture-point detection.
  assign addr_ok_c    = 32'(bus.cmd_addr) < WORD_COUNT;
  assign phase_last_c = (phase == '1);
  assign rd_slot_c    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
  assign rd_hit_c     = (phase == '0) && (slot == rd_slot_c);

  // State and command/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (cmd_load) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
      end
    end
  end

  // Next-state, command latch and response generation.
  always_comb begin
    state_d     = state_q;
    cmd_load    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (addr_ok_c) begin
            cmd_load = 1'b1;
            state_d  = bus.cmd_we ? WAIT_WR : WAIT_RD;
          end else begin
            // Out-of-range: answer immediately, reads return zero.
            rsp_valid_d = 1'b1;
            if (!bus.cmd_we) begin
              rsp_rdata_d = '0;
            end
          end
        end
      end
      WAIT_WR: begin
        // Start shifting so the first bit lands while slot equals the address.
        if (phase_last_c && (next_slot == addr_q)) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_last_c) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      WAIT_RD: begin
        if (rd_hit_c) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ring_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and ring drive; serial data goes out LSB first.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ring_write    = (state_q == SHIFT);
  assign ring_din      = ring_write & wdata_q[phase];
  assign slot_addr     = slot;

endmodule

// File: tb/tb_ring_access_sequencer.sv
// Scoreboard bench for ring_access_sequencer with a byte-level ring model.
module tb_ring_access_sequencer;
  import ring_pkg::*;

  localparam int WC = int'(RING_WORD_COUNT);
  localparam int AW = int'(RING_ADDR_W);

  typedef struct {
    bit         is_read;
    bit         oor;
    logic [7:0] data;
    int         addr;
    int         acc;
    int         rsp;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    ring_q;
  logic          ring_write;
  logic          ring_din;
  logic [AW-1:0] slot_addr;

  int   cyc = 0;
  int   wd = 0;
  int   checks = 0;
  int   fails = 0;
  int   accept_count = 0;
  int   rsp_count = 0;
  int   aborted = 0;
  int   prev_slot;
  bit   mem_cleared = 1'b0;
  bit   mon_busy = 1'b0;
  bit   mon_leak = 1'b0;
  exp_t mon_e;
  exp_t exp_q[$];

  logic [7:0] ring_mem [WC];
  logic [7:0] ref_mem [WC];

  ring_access_sequencer_if #(.ADDR_W(RING_ADDR_W)) bus ();

  ring_access_sequencer #(
    .WORD_COUNT (RING_WORD_COUNT),
    .ADDR_W     (RING_ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ring_q     (ring_q),
    .ring_write (ring_write),
    .ring_din   (ring_din),
    .slot_addr  (slot_addr)
  );

  always #5 clk = ~clk;

  function automatic int slot_of(input int c);
    return (c / 8) % WC;
  endfunction

  // Cycle index since reset release: phase = cyc%8, slot = (cyc/8)%WC.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Ring model: bytes by address; byte A is visible while the slot after A passes.
  assign prev_slot = (slot_of(cyc) + WC - 1) % WC;
  assign ring_q    = ring_mem[prev_slot];

  always @(posedge clk) begin
    if (!mem_cleared) begin
      for (int i = 0; i < WC; i++) ring_mem[i] <= 8'h00;
      mem_cleared <= 1'b1;
    end else if (!reset && ring_write) begin
      ring_mem[slot_of(cyc)][cyc % 8] <= ring_din;
    end
  end

  always @(posedge clk) begin
    wd++;
    if (wd > 60000) begin
      $display("FAIL watchdog: cycle budget exceeded (got %0d cycles, limit 60000)", wd);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Response cycle derived from the rotation rules for a command accepted in cycle g.
  function automatic int exp_rsp_cycle(input bit we, input int addr, input int g);
    if (addr >= WC) return g + 1;
    if (we) begin
      for (int s = g + 2; s < g + 2 + 8 * WC + 8; s++)
        if ((s % 8 == 0) && (slot_of(s) == addr)) return s + 8;
    end else begin
      for (int p = g + 1; p < g + 1 + 8 * WC + 8; p++)
        if ((p % 8 == 0) && (slot_of(p) == (addr + 1) % WC)) return p + 1;
    end
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      mon_busy = 1'b0;
      mon_leak = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no outstanding response at cycle %0d", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_cycle", cyc, mon_e.rsp);
          if (mon_e.is_read) check("rsp_rdata", int'(bus.rsp_rdata), int'(mon_e.data));
          if (mon_e.is_read && !mon_e.oor)
            check("rd_latency_bound", int'((cyc - mon_e.acc) <= 8 * WC + 1), 1);
          if (!mon_e.oor) check("ready_low_while_busy", int'(mon_leak), 0);
        end
        mon_busy = 1'b0;
        mon_leak = 1'b0;
      end else if (mon_busy && bus.cmd_ready) begin
        mon_leak = 1'b1;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        accept_count++;
        mon_busy = (int'(bus.cmd_addr) < WC);
      end
    end
  end

  // Present a command (called at a falling edge), wait for accept, push expectation.
  task automatic issue(input bit we, input int addr, input logic [7:0] data, input bit hold);
    exp_t e;
    int   n;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_wdata = data;
    n = 0;
    while (!bus.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.is_read = !we;
    e.oor     = (addr >= WC);
    e.addr    = addr;
    e.acc     = cyc;
    e.data    = (!we && addr < WC) ? ref_mem[addr] : 8'h00;
    e.rsp     = exp_rsp_cycle(we, addr, cyc);
    exp_q.push_back(e);
    if (we && addr < WC) ref_mem[addr] = data;
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int         n;
    int         acc0;
    int         rsp0;
    int         last_wr;
    int         addr;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    for (int i = 0; i < WC; i++) ref_mem[i] = 8'h00;

    do_reset(3);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
    check("rst_ring_write", int'(ring_write), 0);
    check("rst_ring_din", int'(ring_din), 0);
    check("rst_slot_addr", int'(slot_addr), 0);

    // Write 0xA5 to address 3 accepted in cycle 0: serial window and ring contents.
    pat = 8'hA5;
    issue(1'b1, 3, pat, 1'b0);
    while (cyc <= 200) begin
      if (cyc < 40) begin
        check("t1_ring_write", int'(ring_write), int'(cyc >= 24 && cyc <= 31));
        check("t1_ring_din", int'(ring_din), (cyc >= 24 && cyc <= 31) ? int'(pat[cyc - 24]) : 0);
      end
      check("t1_slot_addr", int'(slot_addr), slot_of(cyc));
      if (cyc == 32 || cyc == 192) check("t1_ring_q", int'(ring_q), 32'hA5);
      @(negedge clk);
    end
    wait_idle();

    // Write then read address 0.
    issue(1'b1, 0, 8'h3C, 1'b0);
    issue(1'b0, 0, 8'h00, 1'b0);
    wait_idle();

    // Out-of-range read: immediate zero response, no ring activity.
    issue(1'b0, 25, 8'h00, 1'b0);
    repeat (16) begin
      check("oor_no_ring_write", int'(ring_write), 0);
      @(negedge clk);
    end
    wait_idle();

    // Reset in the middle of a shift, then a clean write to address 1.
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = AW'(5);
    bus.cmd_wdata = 8'h5A;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    aborted++;
    n = 0;
    while (!(ring_write && (cyc % 8 == 4)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_shift_phase4", int'(ring_write && (cyc % 8 == 4)), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ring_write_dropped", int'(ring_write), 0);
    check("abort_no_rsp", int'(bus.rsp_valid), 0);
    reset = 1'b0;
    issue(1'b1, 1, 8'hFF, 1'b0);
    while (cyc <= 20) begin
      check("post_reset_ring_write", int'(ring_write), int'(cyc >= 8 && cyc <= 15));
      if (cyc >= 8 && cyc <= 15) check("post_reset_ring_din", int'(ring_din), 1);
      @(negedge clk);
    end
    wait_idle();

    // Fill every address, read back in reverse order.
    for (int i = 0; i < WC; i++) issue(1'b1, i, 8'(8'h10 + i), 1'b0);
    for (int i = WC - 1; i >= 0; i--) issue(1'b0, i, 8'h00, 1'b0);
    wait_idle();
    for (int i = 0; i < WC; i++) check("fill_ring_contents", int'(ring_mem[i]), 16 + i);

    // cmd_valid held high across alternating random writes and reads.
    acc0 = accept_count;
    rsp0 = rsp_count;
    last_wr = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        addr = int'($urandom_range(0, WC + 3));
        if (addr < WC) last_wr = addr;
        issue(1'b1, addr, 8'($urandom), 1'b1);
      end else begin
        addr = ($urandom_range(0, 1) == 0) ? last_wr : int'($urandom_range(0, 31));
        issue(1'b0, addr, 8'h00, (k != 39));
      end
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    check("held_valid_accepts", accept_count - acc0, 40);
    check("held_valid_rsps", rsp_count - rsp0, 40);

    check("accepts_eq_rsps", accept_count, rsp_count + aborted);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
